mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 255, cycles in WAIT_ACK before err_o sets (8-bit counter, 1..255).
REQ-002 clk_i  in  1  clock, rising edge.
REQ-003 rst_i  in  1  reset, asynchronous, active-low.
REQ-004 p0_enable_i / p1_enable_i  in  1  request (port 0 = I-cache, port 1 = D-cache); held high until own ack.
REQ-005 p0_write_i / p1_write_i  in  1  1 = write, 0 = read.
REQ-006 p0_addr_i / p1_addr_i  in  32  block address, bits [4:0] zero.
REQ-007 p0_data_i / p1_data_i  in  256  write block.
REQ-008 p0_ack_o / p1_ack_o  out  1  transaction complete for that port.
REQ-009 p0_data_o / p1_data_o  out  256  read block.
REQ-010 mem_enable_o, mem_write_o  out  1 each  memory request / write select.
REQ-011 mem_addr_o  out  32;  mem_data_o  out  256  to memory.
REQ-012 mem_ack_i  in  1;  mem_data_i  in  256  from memory.
REQ-013 err_o  out  1  sticky timeout flag.

Function
REQ-014 States SHALL be IDLE, WAIT_ACK, RELEASE; one grant register gnt (0/1) and one last-served register last.
REQ-015 IDLE: neither request -> stay IDLE; exactly one -> grant it; both -> grant port != last; go WAIT_ACK.
REQ-016 On entering WAIT_ACK, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o SHALL be registered from the granted port; request seen at edge N -> mem_enable_o high after edge N+1 (1-cycle latency).
REQ-017 Memory-side outputs SHALL remain constant throughout WAIT_ACK, even if the granted requester deasserts enable.
REQ-018 WAIT_ACK with mem_ack_i=1: granted port's pN_ack_o SHALL be 1 in that same cycle (combinational), pN_data_o = mem_data_i; other port's ack 0.
REQ-019 Edge where mem_ack_i=1 in WAIT_ACK: mem_enable_o<=0, mem_write_o<=0, last<=gnt, state<=RELEASE.
REQ-020 RELEASE: lasts exactly 1 cycle; new grant forbidden (requester's enable still high from registered drop); -> IDLE.
REQ-021 pN_data_o SHALL equal mem_data_i at all times; only acks are gated.
REQ-022 mem_ack_i outside WAIT_ACK SHALL be ignored (no ack output, no state change).
REQ-023 Timeout counter: cleared on entering WAIT_ACK, increments each WAIT_ACK cycle without ack, saturates; reaching TIMEOUT sets err_o, which stays 1 until reset; transaction is not aborted.
REQ-024 Back-to-back: request pending in IDLE after RELEASE SHALL be granted at once; steady dual request SHALL alternate 0,1,0,1.
REQ-025 Write transactions follow identical sequencing; mem_data_o is don't-care for reads but SHALL carry the granted port's data.

Reset
REQ-026 rst_i low asynchronously forces: state IDLE, gnt 0, last 1 (port 0 wins first tie), mem_enable_o 0, mem_write_o 0, mem_addr_o 0, mem_data_o 0, counter 0, err_o 0; acks 0.
REQ-027 Reset mid-transaction SHALL drop mem_enable_o immediately; no ack issued for the aborted transaction.

Structure
REQ-028 State encodings (IDLE=2'd0, WAIT_ACK=2'd1, RELEASE=2'd2) and port IDs SHALL live in the shared memory-system package alongside the cache controller constants.
REQ-029 Single flat module; no sub-module (per-port mux is trivial).

Verification
REQ-030 Only p1 read, addr 0x0000_0400, memory acks after 10 cycles -> mem_enable_o high 1 cycle after request, p1_ack_o pulses once with data, p0_ack_o stays 0.
REQ-031 p0 and p1 request same cycle after reset -> p0 served first, p1 granted in cycle after RELEASE.
REQ-032 Both held continuously for 4 transactions -> grant order 0,1,0,1; no cycle with two acks.
REQ-033 p0 write, addr 0x0000_0020, data 0xA5 pattern -> mem_write_o=1, mem_addr_o/mem_data_o match and stable until ack.
REQ-034 TIMEOUT=8, memory never acks -> err_o rises after 8 WAIT_ACK cycles, stays high; late ack still completes transaction.
REQ-035 rst_i low mid-WAIT_ACK -> mem_enable_o 0 same cycle, state IDLE, no ack; spurious mem_ack_i in IDLE -> no ack outputs.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared memory-system definitions: bus widths used by the cache controllers,
// arbiter state encodings and requester port IDs.
package mem_arbiter_pkg;

   localparam int unsigned MEM_ADDR_W  = 32;
   localparam int unsigned MEM_BLOCK_W = 256;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_ACK = 2'd1,
      ST_RELEASE  = 2'd2
   } arb_state_e;

   localparam logic PORT_ICACHE = 1'b0;
   localparam logic PORT_DCACHE = 1'b1;

   // A tie goes to the port that was not served last.
   function automatic logic pick_port(input logic p0_req, input logic p1_req, input logic last);
      logic sel;
      if (p0_req && p1_req) begin
         sel = ~last;
      end else if (p1_req) begin
         sel = PORT_DCACHE;
      end else begin
         sel = PORT_ICACHE;
      end
      return sel;
   endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (I-cache / D-cache) arbiter in front of a single block memory.
// Round-robin on ties, registered memory request, sticky ack-timeout flag.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   p0_enable_i,
   input  logic                   p0_write_i,
   input  logic [MEM_ADDR_W-1:0]  p0_addr_i,
   input  logic [MEM_BLOCK_W-1:0] p0_data_i,
   output logic                   p0_ack_o,
   output logic [MEM_BLOCK_W-1:0] p0_data_o,
   input  logic                   p1_enable_i,
   input  logic                   p1_write_i,
   input  logic [MEM_ADDR_W-1:0]  p1_addr_i,
   input  logic [MEM_BLOCK_W-1:0] p1_data_i,
   output logic                   p1_ack_o,
   output logic [MEM_BLOCK_W-1:0] p1_data_o,
   output logic                   mem_enable_o,
   output logic                   mem_write_o,
   output logic [MEM_ADDR_W-1:0]  mem_addr_o,
   output logic [MEM_BLOCK_W-1:0] mem_data_o,
   input  logic                   mem_ack_i,
   input  logic [MEM_BLOCK_W-1:0] mem_data_i,
   output logic                   err_o
);

   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

   arb_state_e             r_state;
   logic                   r_gnt;
   logic                   r_last;
   logic                   r_mem_enable;
   logic                   r_mem_write;
   logic [MEM_ADDR_W-1:0]  r_mem_addr;
   logic [MEM_BLOCK_W-1:0] r_mem_data;
   logic [7:0]             r_cnt;
   logic                   r_err;

   arb_state_e             w_state_nxt;
   logic                   w_gnt_nxt;
   logic                   w_last_nxt;
   logic                   w_mem_enable_nxt;
   logic                   w_mem_write_nxt;
   logic [MEM_ADDR_W-1:0]  w_mem_addr_nxt;
   logic [MEM_BLOCK_W-1:0] w_mem_data_nxt;
   logic [7:0]             w_cnt_nxt;
   logic                   w_err_nxt;
   logic                   w_sel;
   logic [7:0]             w_cnt_inc;
   logic                   w_ack_live;

   // State and memory-side request registers.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state      <= ST_IDLE;
         r_gnt        <= PORT_ICACHE;
         r_last       <= PORT_DCACHE;
         r_mem_enable <= 1'b0;
         r_mem_write  <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_data   <= '0;
         r_cnt        <= 8'd0;
         r_err        <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_gnt        <= w_gnt_nxt;
         r_last       <= w_last_nxt;
         r_mem_enable <= w_mem_enable_nxt;
         r_mem_write  <= w_mem_write_nxt;
         r_mem_addr   <= w_mem_addr_nxt;
         r_mem_data   <= w_mem_data_nxt;
         r_cnt        <= w_cnt_nxt;
         r_err        <= w_err_nxt;
      end
   end

   // Next-state, grant selection and timeout bookkeeping.
   always_comb begin
      w_state_nxt      = r_state;
      w_gnt_nxt        = r_gnt;
      w_last_nxt       = r_last;
      w_mem_enable_nxt = r_mem_enable;
      w_mem_write_nxt  = r_mem_write;
      w_mem_addr_nxt   = r_mem_addr;
      w_mem_data_nxt   = r_mem_data;
      w_cnt_nxt        = r_cnt;
      w_err_nxt        = r_err;
      w_sel            = pick_port(p0_enable_i, p1_enable_i, r_last);
      w_cnt_inc        = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;

      case (r_state)
         ST_IDLE: begin
            if (p0_enable_i || p1_enable_i) begin
               w_state_nxt      = ST_WAIT_ACK;
               w_gnt_nxt        = w_sel;
               w_mem_enable_nxt = 1'b1;
               w_mem_write_nxt  = w_sel ? p1_write_i : p0_write_i;
               w_mem_addr_nxt   = w_sel ? p1_addr_i  : p0_addr_i;
               w_mem_data_nxt   = w_sel ? p1_data_i  : p0_data_i;
               w_cnt_nxt        = 8'd0;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_WAIT_ACK: begin
            if (mem_ack_i) begin
               w_state_nxt      = ST_RELEASE;
               w_mem_enable_nxt = 1'b0;
               w_mem_write_nxt  = 1'b0;
               w_last_nxt       = r_gnt;
            end else begin
               w_cnt_nxt = w_cnt_inc;
               // Slow memory is only flagged; the transaction keeps waiting.
               if (w_cnt_inc >= TIMEOUT_C) begin
                  w_err_nxt = 1'b1;
               end else begin
                  w_err_nxt = r_err;
               end
            end
         end
         ST_RELEASE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt      = ST_IDLE;
            w_mem_enable_nxt = 1'b0;
            w_mem_write_nxt  = 1'b0;
         end
      endcase
   end

   // Acks follow mem_ack_i in the same cycle so the cache can latch data without delay.
   assign w_ack_live   = (r_state == ST_WAIT_ACK) && mem_ack_i;
   assign p0_ack_o     = w_ack_live && (r_gnt == PORT_ICACHE);
   assign p1_ack_o     = w_ack_live && (r_gnt == PORT_DCACHE);
   assign p0_data_o    = mem_data_i;
   assign p1_data_o    = mem_data_i;
   assign mem_enable_o = r_mem_enable;
   assign mem_write_o  = r_mem_write;
   assign mem_addr_o   = r_mem_addr;
   assign mem_data_o   = r_mem_data;
   assign err_o        = r_err;

endmodule
